// File: rtl/erbium_kernel_ctrl_pkg.sv
// Shared types and constants for the erbium kernel job controller.
package erbium_kernel_ctrl_pkg;

  localparam int unsigned DefDataBusWidth   = 512;
  localparam int unsigned DefHashWidth      = 64;
  localparam int unsigned DefCntWidth       = 32;
  localparam int unsigned DefEdgeWaitCycles = 1;

  localparam logic STYPE_NFA   = 1'b0;
  localparam logic STYPE_QUERY = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StReadNfa,
    StWaitEdges,
    StReadQuery,
    StDrain,
    StDone
  } ctrl_state_t;

endpackage

// File: rtl/erbium_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module erbium_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/erbium_kernel_ctrl.sv
// Job controller: ap_ctrl_hs handshake, NFA reload decision and phase-gated stream routing
// between the host AXI4-Stream pipes and the erbium engine.
module erbium_kernel_ctrl
  import erbium_kernel_ctrl_pkg::*;
#(
  parameter int unsigned G_DATA_BUS_WIDTH   = DefDataBusWidth,
  parameter int unsigned G_HASH_WIDTH       = DefHashWidth,
  parameter int unsigned G_CNT_WIDTH        = DefCntWidth,
  parameter int unsigned G_EDGE_WAIT_CYCLES = DefEdgeWaitCycles
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ap_start_i,
  output logic                          ap_idle_o,
  output logic                          ap_done_o,
  output logic                          ap_ready_o,
  input  logic [G_HASH_WIDTH-1:0]       nfa_hash_i,
  input  logic                          force_reload_i,
  input  logic [G_DATA_BUS_WIDTH-1:0]   in_tdata,
  input  logic [G_DATA_BUS_WIDTH/8-1:0] in_tkeep,
  input  logic                          in_tvalid,
  input  logic                          in_tlast,
  output logic                          in_tready,
  output logic [G_DATA_BUS_WIDTH-1:0]   eng_rd_data,
  output logic                          eng_rd_valid,
  output logic                          eng_rd_last,
  output logic                          eng_rd_stype,
  input  logic                          eng_rd_ready,
  input  logic [G_DATA_BUS_WIDTH-1:0]   eng_wr_data,
  input  logic                          eng_wr_valid,
  input  logic                          eng_wr_last,
  output logic                          eng_wr_ready,
  output logic [G_DATA_BUS_WIDTH-1:0]   res_tdata,
  output logic [G_DATA_BUS_WIDTH/8-1:0] res_tkeep,
  output logic                          res_tvalid,
  output logic                          res_tlast,
  input  logic                          res_tready,
  output logic [G_CNT_WIDTH-1:0]        nfa_beats_o,
  output logic [G_CNT_WIDTH-1:0]        query_beats_o,
  output logic [G_CNT_WIDTH-1:0]        result_beats_o,
  output logic                          reloaded_o
);

  localparam int unsigned WaitW = (G_EDGE_WAIT_CYCLES > 1) ? $clog2(G_EDGE_WAIT_CYCLES) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(G_EDGE_WAIT_CYCLES - 1);

  ctrl_state_t state_d, state_q;
  logic [G_HASH_WIDTH-1:0] hash_d, hash_q, hash_start_d, hash_start_q;
  logic hash_valid_d, hash_valid_q;
  logic reloaded_d, reloaded_q;
  logic res_seen_d, res_seen_q;
  logic [WaitW-1:0] wait_d, wait_q;

  logic reload, in_phase, res_en, in_hs, res_hs, res_last_hs, start_acc;

  // Keep is implied by the engine protocol and not forwarded.
  logic unused_tkeep;
  assign unused_tkeep = ^in_tkeep;

  assign reload    = force_reload_i | ~hash_valid_q | (nfa_hash_i != hash_q);
  assign in_phase  = (state_q == StReadNfa) || (state_q == StReadQuery);
  assign res_en    = (state_q == StReadQuery) || (state_q == StDrain);
  assign start_acc = (state_q == StIdle) && ap_start_i;

  assign in_tready    = eng_rd_ready & in_phase;
  assign eng_rd_valid = in_tvalid & in_phase;
  assign eng_rd_data  = in_tdata;
  assign eng_rd_last  = in_tlast;
  assign eng_rd_stype = (state_q == StReadNfa) ? STYPE_NFA : STYPE_QUERY;

  assign res_tvalid   = eng_wr_valid & res_en;
  assign eng_wr_ready = res_tready & res_en;
  assign res_tdata    = eng_wr_data;
  assign res_tlast    = eng_wr_last;
  assign res_tkeep    = '1;

  assign in_hs       = in_tvalid & in_tready;
  assign res_hs      = res_tvalid & res_tready;
  assign res_last_hs = res_hs & eng_wr_last;

  assign ap_idle_o  = (state_q == StIdle);
  assign ap_done_o  = (state_q == StDone);
  assign ap_ready_o = (state_q == StDone);
  assign reloaded_o = reloaded_q;

  always_comb begin
    state_d      = state_q;
    hash_d       = hash_q;
    hash_valid_d = hash_valid_q;
    hash_start_d = hash_start_q;
    reloaded_d   = reloaded_q;
    res_seen_d   = res_seen_q;
    wait_d       = wait_q;
    unique case (state_q)
      StIdle: begin
        if (ap_start_i) begin
          state_d      = reload ? StReadNfa : StWaitEdges;
          hash_start_d = nfa_hash_i;
          reloaded_d   = reload;
          res_seen_d   = 1'b0;
          wait_d       = '0;
        end
      end
      StReadNfa: begin
        if (in_hs && in_tlast) begin
          hash_d       = hash_start_q;
          hash_valid_d = 1'b1;
          wait_d       = '0;
          state_d      = StWaitEdges;
        end
      end
      StWaitEdges: begin
        if (wait_q == WaitLast) state_d = StReadQuery;
        else                    wait_d  = wait_q + WaitW'(1);
      end
      StReadQuery: begin
        if (res_last_hs) res_seen_d = 1'b1;
        // A result tlast in the same cycle as the query tlast still closes the job.
        if (in_hs && in_tlast) state_d = (res_seen_q || res_last_hs) ? StDone : StDrain;
      end
      StDrain: begin
        if (res_last_hs) begin
          res_seen_d = 1'b1;
          state_d    = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
      hash_start_q <= '0;
      reloaded_q   <= 1'b0;
      res_seen_q   <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
      hash_start_q <= hash_start_d;
      reloaded_q   <= reloaded_d;
      res_seen_q   <= res_seen_d;
      wait_q       <= wait_d;
    end
  end

  erbium_sat_counter #(.Width(G_CNT_WIDTH)) u_nfa_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (start_acc),
    .inc_i (in_hs && (state_q == StReadNfa)),
    .cnt_o (nfa_beats_o)
  );

  erbium_sat_counter #(.Width(G_CNT_WIDTH)) u_query_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (start_acc),
    .inc_i (in_hs && (state_q == StReadQuery)),
    .cnt_o (query_beats_o)
  );

  erbium_sat_counter #(.Width(G_CNT_WIDTH)) u_result_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (start_acc),
    .inc_i (res_hs),
    .cnt_o (result_beats_o)
  );

endmodule

// File: tb/tb_erbium_kernel_ctrl.sv
// Randomized self-checking bench for erbium_kernel_ctrl against a job-level reference model.
module tb_erbium_kernel_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned KW = W / 8;
  localparam int unsigned H  = 16;
  localparam int unsigned C  = 4;
  localparam int unsigned E  = 2;
  localparam int SatMax = (1 << C) - 1;

  logic clk = 1'b0;
  logic rst_i;
  logic ap_start_i, ap_idle_o, ap_done_o, ap_ready_o;
  logic [H-1:0] nfa_hash_i;
  logic force_reload_i;
  logic [W-1:0] in_tdata, eng_rd_data, eng_wr_data, res_tdata;
  logic [KW-1:0] in_tkeep, res_tkeep;
  logic in_tvalid, in_tlast, in_tready;
  logic eng_rd_valid, eng_rd_last, eng_rd_stype, eng_rd_ready;
  logic eng_wr_valid, eng_wr_last, eng_wr_ready;
  logic res_tvalid, res_tlast, res_tready;
  logic [C-1:0] nfa_beats_o, query_beats_o, result_beats_o;
  logic reloaded_o;

  int checks = 0;
  int fails  = 0;

  // Reference model: controller-visible job history.
  logic [H-1:0] m_hash  = '0;
  bit           m_valid = 1'b0;
  int           m_nfa = 0, m_q = 0, m_res = 0;
  bit           m_reloaded = 1'b0;

  always #5 clk = ~clk;

  erbium_kernel_ctrl #(
    .G_DATA_BUS_WIDTH   (W),
    .G_HASH_WIDTH       (H),
    .G_CNT_WIDTH        (C),
    .G_EDGE_WAIT_CYCLES (E)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .ap_start_i     (ap_start_i),
    .ap_idle_o      (ap_idle_o),
    .ap_done_o      (ap_done_o),
    .ap_ready_o     (ap_ready_o),
    .nfa_hash_i     (nfa_hash_i),
    .force_reload_i (force_reload_i),
    .in_tdata       (in_tdata),
    .in_tkeep       (in_tkeep),
    .in_tvalid      (in_tvalid),
    .in_tlast       (in_tlast),
    .in_tready      (in_tready),
    .eng_rd_data    (eng_rd_data),
    .eng_rd_valid   (eng_rd_valid),
    .eng_rd_last    (eng_rd_last),
    .eng_rd_stype   (eng_rd_stype),
    .eng_rd_ready   (eng_rd_ready),
    .eng_wr_data    (eng_wr_data),
    .eng_wr_valid   (eng_wr_valid),
    .eng_wr_last    (eng_wr_last),
    .eng_wr_ready   (eng_wr_ready),
    .res_tdata      (res_tdata),
    .res_tkeep      (res_tkeep),
    .res_tvalid     (res_tvalid),
    .res_tlast      (res_tlast),
    .res_tready     (res_tready),
    .nfa_beats_o    (nfa_beats_o),
    .query_beats_o  (query_beats_o),
    .result_beats_o (result_beats_o),
    .reloaded_o     (reloaded_o)
  );

  function automatic int sat(input int n);
    return (n > SatMax) ? SatMax : n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ap_start_i = 1'b0; nfa_hash_i = '0; force_reload_i = 1'b0;
    in_tdata = '0; in_tkeep = '1; in_tvalid = 1'b0; in_tlast = 1'b0; eng_rd_ready = 1'b0;
    eng_wr_data = '0; eng_wr_valid = 1'b0; eng_wr_last = 1'b0; res_tready = 1'b0;
  endtask

  // Drives one complete job and checks every cycle against the model.
  task automatic run_job(input logic [H-1:0] hash, input bit frc, input int n_nfa, input int n_q,
                         input int n_res, input int res_start, input bit rnd_rd, input bit tog_res);
    bit exp_reload, qdone, rseen, fin;
    int sent, waited, qsent, rsent, cyc;
    exp_reload = frc || !m_valid || (hash != m_hash);
    checks++;
    if (ap_idle_o !== 1'b1) begin
      fails++; $display("FAIL job_idle_before: ap_idle_o=%b required 1", ap_idle_o);
    end
    ap_start_i = 1'b1; nfa_hash_i = hash; force_reload_i = frc;
    tick;
    // Hash and force after acceptance must be ignored.
    ap_start_i = 1'b0; nfa_hash_i = H'($urandom); force_reload_i = 1'($urandom);
    #1;
    checks++;
    if ({ap_idle_o, reloaded_o} !== {1'b0, exp_reload}) begin
      fails++; $display("FAIL job_accept: idle,reloaded=%b%b required 0%b", ap_idle_o, reloaded_o,
                        exp_reload);
    end
    checks++;
    if ({nfa_beats_o, query_beats_o, result_beats_o} !== '0) begin
      fails++; $display("FAIL job_cnt_clear: counts=%0d/%0d/%0d required 0/0/0", nfa_beats_o,
                        query_beats_o, result_beats_o);
    end
    if (exp_reload) begin
      sent = 0; cyc = 0;
      while (sent < n_nfa && cyc < 200) begin
        in_tvalid = ($urandom_range(0, 3) != 0); in_tdata = $urandom;
        in_tlast = (sent == n_nfa - 1); eng_rd_ready = rnd_rd ? 1'($urandom) : 1'b1;
        eng_wr_valid = 1'b1; res_tready = 1'b1; ap_start_i = 1'($urandom);
        #1;
        checks++;
        if ({in_tready, eng_rd_valid, eng_rd_stype, eng_rd_last, res_tvalid, eng_wr_ready} !==
            {eng_rd_ready, in_tvalid, 1'b0, in_tlast, 1'b0, 1'b0}) begin
          fails++; $display("FAIL nfa_path: rdy,vld,stype,last,rvld,wrdy=%b%b%b%b%b%b required %b%b0%b00",
                            in_tready, eng_rd_valid, eng_rd_stype, eng_rd_last, res_tvalid,
                            eng_wr_ready, eng_rd_ready, in_tvalid, in_tlast);
        end
        checks++;
        if (eng_rd_data !== in_tdata) begin
          fails++; $display("FAIL nfa_data: got %h required %h", eng_rd_data, in_tdata);
        end
        if (in_tvalid && eng_rd_ready) sent++;
        cyc++;
        tick;
      end
      checks++;
      if (sent != n_nfa) begin
        fails++; $display("FAIL nfa_budget: sent %0d beats required %0d", sent, n_nfa);
      end
      m_hash = hash; m_valid = 1'b1;
    end
    ap_start_i = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; eng_rd_ready = 1'b1;
    eng_wr_valid = 1'b0;
    waited = 0;
    #1;
    while (in_tready !== 1'b1 && waited < 50) begin
      waited++;
      tick;
    end
    checks++;
    if (waited != E) begin
      fails++; $display("FAIL edge_wait: waited %0d cycles required %0d", waited, E);
    end
    qsent = 0; rsent = 0; qdone = 0; rseen = 0; fin = 0; cyc = 0;
    while (!fin && cyc < 400) begin
      in_tvalid = !qdone; in_tlast = (qsent == n_q - 1); in_tdata = $urandom;
      eng_rd_ready = rnd_rd ? 1'($urandom) : 1'b1;
      eng_wr_valid = (cyc >= res_start) && (rsent < n_res); eng_wr_last = (rsent == n_res - 1);
      eng_wr_data = $urandom; res_tready = tog_res ? 1'(cyc) : 1'b1;
      #1;
      checks++;
      if ({in_tready, eng_rd_valid, eng_rd_stype, res_tvalid, eng_wr_ready, res_tlast, ap_done_o} !==
          {eng_rd_ready & !qdone, in_tvalid, 1'b1, eng_wr_valid, res_tready, eng_wr_last, 1'b0}) begin
        fails++; $display("FAIL query_path: cyc %0d rdy,vld,stype,rvld,wrdy,rlast,done=%b%b%b%b%b%b%b",
                          cyc, in_tready, eng_rd_valid, eng_rd_stype, res_tvalid, eng_wr_ready,
                          res_tlast, ap_done_o);
      end
      checks++;
      if ({res_tdata, res_tkeep, eng_rd_data} !== {eng_wr_data, {KW{1'b1}}, in_tdata}) begin
        fails++; $display("FAIL query_data: res %h keep %h rd %h required %h %h %h", res_tdata,
                          res_tkeep, eng_rd_data, eng_wr_data, {KW{1'b1}}, in_tdata);
      end
      if (eng_wr_valid && res_tready) begin
        rsent++;
        if (eng_wr_last) rseen = 1'b1;
      end
      if (in_tvalid && eng_rd_ready) begin
        if (in_tlast) qdone = 1'b1;
        qsent++;
      end
      fin = qdone && rseen;
      cyc++;
      tick;
    end
    in_tvalid = 1'b0; eng_wr_valid = 1'b0; eng_rd_ready = 1'b1; res_tready = 1'b1;
    #1;
    checks++;
    if ({ap_done_o, ap_ready_o, ap_idle_o, in_tready, eng_wr_ready} !== 5'b11000) begin
      fails++; $display("FAIL done_pulse: done,ready,idle,irdy,wrdy=%b%b%b%b%b required 11000 (fin=%b)",
                        ap_done_o, ap_ready_o, ap_idle_o, in_tready, eng_wr_ready, fin);
    end
    tick;
    checks++;
    if ({ap_done_o, ap_ready_o, ap_idle_o} !== 3'b001) begin
      fails++; $display("FAIL done_width: done,ready,idle=%b%b%b required 001", ap_done_o,
                        ap_ready_o, ap_idle_o);
    end
    m_nfa = exp_reload ? sat(n_nfa) : 0; m_q = sat(n_q); m_res = sat(n_res);
    m_reloaded = exp_reload;
    checks++;
    if ({nfa_beats_o, query_beats_o, result_beats_o, reloaded_o} !==
        {C'(m_nfa), C'(m_q), C'(m_res), m_reloaded}) begin
      fails++; $display("FAIL job_counts: %0d/%0d/%0d rel=%b required %0d/%0d/%0d rel=%b",
                        nfa_beats_o, query_beats_o, result_beats_o, reloaded_o, m_nfa, m_q, m_res,
                        m_reloaded);
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_i = 1'b1;
    eng_rd_ready = 1'b1; eng_wr_valid = 1'b1; res_tready = 1'b1; in_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ap_idle_o, ap_done_o, ap_ready_o, in_tready, eng_wr_ready, res_tvalid, reloaded_o} !==
        7'b1000000) begin
      fails++; $display("FAIL reset_outputs: idle,done,ready,irdy,wrdy,rvld,rel=%b%b%b%b%b%b%b required 1000000",
                        ap_idle_o, ap_done_o, ap_ready_o, in_tready, eng_wr_ready, res_tvalid,
                        reloaded_o);
    end
    checks++;
    if ({nfa_beats_o, query_beats_o, result_beats_o} !== '0) begin
      fails++; $display("FAIL reset_counts: %0d/%0d/%0d required 0/0/0", nfa_beats_o,
                        query_beats_o, result_beats_o);
    end
    clear_inputs();
    rst_i = 1'b0;
    m_valid = 1'b0;
    tick;
  endtask

  task automatic test_basic_jobs;
    run_job(16'h0000, 1'b0, 3, 5, 2, 1, 1'b0, 1'b0);
    run_job(16'h0000, 1'b0, 3, 5, 2, 1, 1'b0, 1'b0);
    run_job(16'h0000, 1'b1, 2, 4, 1, 0, 1'b1, 1'b0);
    run_job(16'hDEAD, 1'b0, 4, 3, 2, 2, 1'b1, 1'b0);
    run_job(16'hDEAD, 1'b0, 2, 3, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_drain;
    run_job(16'hDEAD, 1'b0, 1, 5, 2, 7, 1'b0, 1'b1);
  endtask

  task automatic test_coincident;
    run_job(16'hDEAD, 1'b0, 1, 5, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_idle_gate;
    in_tvalid = 1'b1; in_tlast = 1'b1; eng_rd_ready = 1'b1;
    eng_wr_valid = 1'b1; eng_wr_last = 1'b1; res_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({in_tready, eng_rd_valid, res_tvalid, eng_wr_ready, ap_idle_o} !== 5'b00001) begin
        fails++; $display("FAIL idle_gate: irdy,rvld,resv,wrdy,idle=%b%b%b%b%b required 00001",
                          in_tready, eng_rd_valid, res_tvalid, eng_wr_ready, ap_idle_o);
      end
      tick;
    end
    checks++;
    if ({nfa_beats_o, query_beats_o, result_beats_o} !== {C'(m_nfa), C'(m_q), C'(m_res)}) begin
      fails++; $display("FAIL idle_counts: %0d/%0d/%0d required %0d/%0d/%0d", nfa_beats_o,
                        query_beats_o, result_beats_o, m_nfa, m_q, m_res);
    end
    clear_inputs();
  endtask

  task automatic test_saturation;
    run_job(16'h5555, 1'b0, 20, 20, 17, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [H-1:0] hashes [3];
    hashes[0] = 16'h0000; hashes[1] = 16'hDEAD; hashes[2] = 16'h1234;
    for (int j = 0; j < 6; j++) begin
      run_job(hashes[$urandom_range(0, 2)], ($urandom_range(0, 4) == 0), $urandom_range(1, 6),
              $urandom_range(1, 8), $urandom_range(1, 4), $urandom_range(0, 10), 1'b1,
              1'($urandom));
    end
  endtask

  task automatic test_reset_mid;
    int waited;
    ap_start_i = 1'b1; nfa_hash_i = m_hash; force_reload_i = 1'b0;
    tick;
    ap_start_i = 1'b0; eng_rd_ready = 1'b1;
    waited = 0;
    #1;
    while (in_tready !== 1'b1 && waited < 50) begin
      waited++;
      tick;
    end
    in_tvalid = 1'b1; in_tlast = 1'b0;
    tick;
    tick;
    eng_wr_valid = 1'b1; res_tready = 1'b1;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({ap_idle_o, in_tready, eng_wr_ready, res_tvalid, ap_done_o, reloaded_o} !== 6'b100000) begin
      fails++; $display("FAIL reset_mid: idle,irdy,wrdy,rvld,done,rel=%b%b%b%b%b%b required 100000",
                        ap_idle_o, in_tready, eng_wr_ready, res_tvalid, ap_done_o, reloaded_o);
    end
    checks++;
    if ({nfa_beats_o, query_beats_o, result_beats_o} !== '0) begin
      fails++; $display("FAIL reset_mid_counts: %0d/%0d/%0d required 0/0/0", nfa_beats_o,
                        query_beats_o, result_beats_o);
    end
    m_valid = 1'b0;
    clear_inputs();
    tick;
    rst_i = 1'b0;
    tick;
    run_job(m_hash, 1'b0, 2, 3, 1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_jobs();
    test_drain();
    test_coincident();
    test_idle_gate();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
